// File: rtl/mult_loader.sv
// mult_loader: front-end sequencer for a registered 8x8 multiplier datapath.
// Steers alternate handshaked bytes into operand A and operand B, waits out
// the datapath pipeline latency, then returns the product with a one-cycle
// strobe and a running count of delivered products.
module mult_loader #(
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic        clk_system,
  input  logic        rst_system,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        abort,
  output logic        EA,
  output logic        EB,
  output logic [7:0]  A,
  output logic [7:0]  B,
  input  logic [15:0] P,
  output logic [15:0] res_data,
  output logic        res_valid,
  output logic [7:0]  res_count
);

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [3:0] LAT = 4'(PIPE_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] res_data_q, res_data_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_count_q, res_count_d;
  logic        xfer;

  // Handshake and operand steering; ready is held low while reset or abort is active
  always_comb begin
    in_ready = rst_system && (state_q != WAIT) && !abort;
    xfer     = in_valid && in_ready;
    EA       = xfer && (state_q == GET_A);
    EB       = xfer && (state_q == GET_B);
    A        = in_data;
    B        = in_data;
  end

  // Next-state logic: abort wins over any handshake or completion in the same cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    res_count_d = res_count_q;
    if (abort) begin
      state_d = GET_A;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        GET_A: begin
          if (xfer) state_d = GET_B;
        end
        GET_B: begin
          if (xfer) begin
            state_d = WAIT;
            cnt_d   = 4'd0;
          end
        end
        WAIT: begin
          if (cnt_q == LAT) begin
            res_data_d  = P;
            res_valid_d = 1'b1;
            res_count_d = res_count_q + 8'd1;
            state_d     = GET_A;
            cnt_d       = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = GET_A;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State and result registers, cleared immediately by the shared datapath reset
  always_ff @(posedge clk_system or negedge rst_system) begin
    if (!rst_system) begin
      state_q     <= GET_A;
      cnt_q       <= 4'd0;
      res_data_q  <= 16'h0000;
      res_valid_q <= 1'b0;
      res_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_count_q <= res_count_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_mult_loader.sv
// tb_mult_loader: drives mult_loader against a behavioural datapath and a
// transaction-level reference model, with table vectors, random traffic and
// hand-written abort/reset/wrap sequences.
module tb_mult_loader;

  localparam int PL = 2;

  logic        clk_system = 1'b0;
  logic        rst_system = 1'b0;
  logic [7:0]  in_data    = 8'd0;
  logic        in_valid   = 1'b0;
  logic        abort      = 1'b0;
  logic        in_ready, EA, EB, res_valid;
  logic [7:0]  A, B, res_count;
  logic [15:0] P, res_data;

  int vectors    = 0;
  int miscompares = 0;

  mult_loader #(.PIPE_LAT(PL)) dut (
    .clk_system(clk_system), .rst_system(rst_system),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .EA(EA), .EB(EB), .A(A), .B(B), .P(P),
    .res_data(res_data), .res_valid(res_valid), .res_count(res_count)
  );

  // Free-running system clock
  always #5 clk_system = ~clk_system;

  // Behavioural datapath: operand registers followed by a PL-deep product pipeline
  logic [7:0]  dp_a, dp_b;
  logic [15:0] dp_pipe [PL];
  always @(posedge clk_system or negedge rst_system) begin
    if (!rst_system) begin
      dp_a <= 8'd0;
      dp_b <= 8'd0;
      for (int i = 0; i < PL; i++) dp_pipe[i] <= 16'd0;
    end else begin
      if (EA) dp_a <= A;
      if (EB) dp_b <= B;
      dp_pipe[0] <= 16'(dp_a) * 16'(dp_b);
      for (int i = 1; i < PL; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
  end
  assign P = dp_pipe[PL-1];

  // Reference model: transaction view of the loader (pair collected, result due PL+1 edges later)
  int          cyc       = 0;
  bit          m_have_a  = 1'b0;
  bit          m_busy    = 1'b0;
  int          m_done_at = 0;
  logic [7:0]  m_a = 8'd0, m_b = 8'd0;
  logic [15:0] exp_data  = 16'd0;
  logic        exp_valid = 1'b0;
  logic [7:0]  exp_count = 8'd0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_have_a  = 1'b0;
    m_busy    = 1'b0;
    exp_data  = 16'd0;
    exp_valid = 1'b0;
    exp_count = 8'd0;
  endtask

  task automatic model_step();
    cyc++;
    exp_valid = 1'b0;
    if (abort) begin
      m_busy   = 1'b0;
      m_have_a = 1'b0;
    end else if (m_busy) begin
      if (cyc == m_done_at) begin
        exp_data  = 16'(m_a) * 16'(m_b);
        exp_valid = 1'b1;
        exp_count = exp_count + 8'd1;
        m_busy    = 1'b0;
        m_have_a  = 1'b0;
      end
    end else if (in_valid) begin
      if (!m_have_a) begin
        m_a      = in_data;
        m_have_a = 1'b1;
      end else begin
        m_b       = in_data;
        m_busy    = 1'b1;
        m_done_at = cyc + PL + 1;
      end
    end
  endtask

  task automatic check_cycle();
    logic exp_ready;
    exp_ready = rst_system && !m_busy && !abort;
    check_output("in_ready", 32'(in_ready), 32'(exp_ready));
    check_output("EA", 32'(EA), 32'(in_valid && exp_ready && !m_have_a));
    check_output("EB", 32'(EB), 32'(in_valid && exp_ready && m_have_a));
    check_output("A", 32'(A), 32'(in_data));
    check_output("B", 32'(B), 32'(in_data));
    check_output("res_valid", 32'(res_valid), 32'(exp_valid));
    check_output("res_data", 32'(res_data), 32'(exp_data));
    check_output("res_count", 32'(res_count), 32'(exp_count));
  endtask

  // Advance the model on every edge (or reset) and compare all outputs shortly after
  always @(posedge clk_system or negedge rst_system) begin
    if (!rst_system) model_reset();
    else model_step();
    #1;
    check_cycle();
  end

  // Present a byte from a negedge until it is accepted; valid stays high afterwards
  task automatic apply_stimulus(input logic [7:0] x);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = x;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk_system);
      #1;
      guard++;
    end
    if (guard >= 50) check_output("byte_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk_system);
  endtask

  // Wait at negedges for the result strobe and compare the product
  task automatic wait_result(input logic [15:0] exp_p, input string name);
    int guard;
    guard = 0;
    while (!res_valid && guard < 40) begin
      @(negedge clk_system);
      guard++;
    end
    if (guard >= 40) check_output({name, "_timeout"}, 32'(res_valid), 32'd1);
    else check_output(name, 32'(res_data), 32'(exp_p));
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          gap;
    logic [15:0] p;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{a: 8'd12,  b: 8'd10,  gap: 0, p: 16'h0078};
    tbl[1] = '{a: 8'd255, b: 8'd255, gap: 4, p: 16'hFE01};
    tbl[2] = '{a: 8'd0,   b: 8'd7,   gap: 0, p: 16'h0000};
    tbl[3] = '{a: 8'd3,   b: 8'd0,   gap: 0, p: 16'h0000};
    tbl[4] = '{a: 8'd200, b: 8'd2,   gap: 0, p: 16'h0190};
    tbl[5] = '{a: 8'd13,  b: 8'd17,  gap: 2, p: 16'h00DD};

    // Reset state
    repeat (3) @(negedge clk_system);
    check_output("reset_in_ready", 32'(in_ready), 32'd0);
    check_output("reset_res_data", 32'(res_data), 32'h0);
    check_output("reset_res_count", 32'(res_count), 32'h0);
    rst_system = 1'b1;
    @(negedge clk_system);

    // Table vectors, back-to-back or with gaps between A and B
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tbl[i].a);
      if (tbl[i].gap > 0) begin
        in_valid = 1'b0;
        repeat (tbl[i].gap) @(negedge clk_system);
      end
      apply_stimulus(tbl[i].b);
      wait_result(tbl[i].p, "table_product");
    end
    in_valid = 1'b0;
    check_output("table_count", 32'(res_count), 32'd6);
    @(negedge clk_system);

    // Abort in WAIT with the counter at 1
    apply_stimulus(8'd9);
    apply_stimulus(8'd9);
    in_valid = 1'b0;
    @(negedge clk_system);
    abort = 1'b1;
    @(negedge clk_system);
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_output("abort_wait_res_valid", 32'(res_valid), 32'd0);
      @(negedge clk_system);
    end
    check_output("abort_wait_count", 32'(res_count), 32'd6);
    apply_stimulus(8'd2);
    apply_stimulus(8'd3);
    wait_result(16'h0006, "after_abort_product");
    in_valid = 1'b0;
    @(negedge clk_system);

    // Abort colliding with a B handshake: the next byte must land in A
    apply_stimulus(8'h0A);
    in_data = 8'h55;
    abort   = 1'b1;
    #1;
    check_output("abort_getb_EB", 32'(EB), 32'd0);
    check_output("abort_getb_ready", 32'(in_ready), 32'd0);
    @(negedge clk_system);
    abort   = 1'b0;
    in_data = 8'h11;
    #1;
    check_output("abort_getb_next_EA", 32'(EA), 32'd1);
    check_output("abort_getb_next_EB", 32'(EB), 32'd0);
    @(negedge clk_system);
    apply_stimulus(8'd4);
    wait_result(16'h0044, "abort_getb_product");
    in_valid = 1'b0;
    check_output("abort_getb_count", 32'(res_count), 32'd8);
    @(negedge clk_system);

    // Random traffic with occasional aborts, checked by the reference model
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      abort    = ($urandom_range(0, 15) == 0);
      @(negedge clk_system);
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    repeat (6) @(negedge clk_system);

    // Count wrap from a fresh reset: 256 products of (k, 1)
    rst_system = 1'b0;
    @(negedge clk_system);
    rst_system = 1'b1;
    @(negedge clk_system);
    for (int k = 0; k < 256; k++) begin
      apply_stimulus(8'(k));
      apply_stimulus(8'd1);
      wait_result(16'(k), "wrap_product");
    end
    in_valid = 1'b0;
    check_output("wrap_count", 32'(res_count), 32'd0);
    @(negedge clk_system);

    // Reset asserted mid-WAIT clears everything at once
    apply_stimulus(8'd7);
    apply_stimulus(8'd7);
    in_valid = 1'b0;
    @(negedge clk_system);
    #2;
    rst_system = 1'b0;
    #1;
    check_output("midreset_res_valid", 32'(res_valid), 32'd0);
    check_output("midreset_res_data", 32'(res_data), 32'h0);
    check_output("midreset_res_count", 32'(res_count), 32'd0);
    check_output("midreset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk_system);
    rst_system = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h21;
    #1;
    check_output("post_reset_EA", 32'(EA), 32'd1);
    check_output("post_reset_EB", 32'(EB), 32'd0);
    @(negedge clk_system);
    apply_stimulus(8'd3);
    wait_result(16'h0063, "post_reset_product");
    in_valid = 1'b0;
    repeat (4) @(negedge clk_system);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
